pong_score_keeper: RTL and testbench
====================================

PONG_SCORE_KEEPER -- requirements
Module: pong_score_keeper

Interface
REQ-001 Parameter GAME_LIMIT, default 5, points needed to win; legal range 1..99.
REQ-002 Parameter SERVE_FRAMES, default 60, frame ticks between a point or new game and the next serve; legal range 1..255.
REQ-003 i_clk  input  1  system clock; the block uses no other clock.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_frame_tick  input  1  one-cycle pulse once per video frame.
REQ-006 i_point_p1  input  1  one-cycle pulse: player 1 scored.
REQ-007 i_point_p2  input  1  one-cycle pulse: player 2 scored.
REQ-008 i_new_game  input  1  one-cycle pulse: debounced start request.
REQ-009 o_score_p1d1 / o_score_p1d2  output  4 each  player 1 score, BCD ones / tens.
REQ-010 o_score_p2d1 / o_score_p2d2  output  4 each  player 2 score, BCD ones / tens.
REQ-011 o_serve  output  1  one-cycle pulse: launch the ball.
REQ-012 o_serve_dir  output  1  0 = serve toward player 1, 1 = toward player 2; valid while o_serve is high.
REQ-013 o_play  output  1  high while in PLAY.
REQ-014 o_finish  output  1  high while in DONE.
REQ-015 o_winner  output  2  00 none, 01 player 1, 10 player 2; held through DONE.

Function
REQ-016 FSM states SHALL be IDLE, SERVE, PLAY and DONE.
REQ-017 IDLE: hold all scores at 0; i_new_game -> SERVE.
REQ-018 SERVE: count i_frame_tick pulses from 0; on the tick that makes the count SERVE_FRAMES, pulse o_serve in the same cycle and move to PLAY next cycle.
REQ-019 PLAY: exactly one of i_point_p1/i_point_p2 high -> increment that player's score on the next edge.
REQ-020 After a score in PLAY: if the win condition holds, go to DONE; otherwise go to SERVE with the serve counter cleared.
REQ-021 Both point inputs high in the same cycle: no score change; go to SERVE with o_serve_dir unchanged (replay).
REQ-022 o_serve_dir after a point: toward the player who conceded; after a new game: 1.
REQ-023 Point pulses outside PLAY are ignored.
REQ-024 i_new_game in any state (PLAY and SERVE included) clears scores, o_winner and the serve counter and enters SERVE; it takes priority over a simultaneous point.
REQ-025 DONE: scores frozen, o_finish = 1, o_winner set; leaves DONE only on i_new_game.
REQ-026 Scores SHALL be held as 7-bit binary counters with parallel BCD digits; the BCD ones digit wraps 9 -> 0 and carries into tens; the BCD outputs always equal the binary value.
REQ-027 Scores saturate at 99; no wrap to 00.
REQ-028 Default win condition: score == GAME_LIMIT.
REQ-029 All outputs are registered; scores update exactly one cycle after the point pulse.

Reset
REQ-030 i_rst has priority over every other input: state IDLE; all score digits 0; o_serve, o_play and o_finish 0; o_winner 00; o_serve_dir 1; serve counter 0.
REQ-031 i_rst asserted mid-SERVE or mid-PLAY discards any pending point and any pending serve.

Configuration
REQ-032 Macro PONG_WIN_BY_TWO_EN defined: a player wins only when their score >= GAME_LIMIT and they lead by >= 2 points.
REQ-033 PONG_WIN_BY_TWO_EN defined: if both scores reach 99 without a winner, the next point wins for its scorer.
REQ-034 PONG_WIN_BY_TWO_EN undefined: win condition is REQ-028 only, and the lead-compare logic is absent.

Verification
REQ-035 Reset, then i_new_game, then 60 frame ticks -> o_serve pulses on tick 60 with o_serve_dir=1; o_play=1 on the next cycle.
REQ-036 In PLAY, 12 p1 points separated by serves (GAME_LIMIT=15) -> p1d2=1, p1d1=2 after the 10th->12th points show correct BCD carry at 9 -> 10.
REQ-037 Default build, p1 reaches 5 -> o_finish=1, o_winner=01; further point pulses leave scores at 5-x.
REQ-038 Both point pulses in one cycle in PLAY -> scores unchanged, state SERVE, o_serve_dir unchanged.
REQ-039 PONG_WIN_BY_TWO_EN defined, score 5-5, p1 scores -> 6-5, no finish; p1 scores again -> 7-5, o_winner=01.
REQ-040 i_rst pulsed mid-PLAY at 3-2 together with i_point_p2 -> all digits 0, state IDLE, o_serve never pulses afterwards without i_new_game.

Source files
------------

// File: rtl/pong_score_keeper.sv
// pong_score_keeper: score, serve timing and game state for a two-player pong game.
// Latency: scores, state flags and winner update one clock after the input pulse.
//   o_serve is the exception: it is asserted combinationally in the same cycle as
//   the frame tick that completes the serve delay, and o_play follows one cycle later.
// Backpressure: none. Every input is a single-cycle pulse. A pulse that arrives in a
//   state that does not use it is dropped.
// Ports:
//   i_clk, i_rst (synchronous, active-high), i_frame_tick, i_point_p1, i_point_p2,
//   i_new_game.
//   o_score_p{1,2}d{1,2}: BCD ones (d1) and tens (d2) digits of each player's score.
//   o_serve / o_serve_dir: ball launch pulse and its direction (1 = toward player 2).
//   o_play, o_finish, o_winner (01 = player 1, 10 = player 2).
// Build option: define PONG_WIN_BY_TWO_EN to require a two-point lead to win. When
//   both players reach 99 in that mode, the next point wins.
module pong_score_keeper #(
  parameter int GAME_LIMIT   = 5,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_point_p1,
  input  logic       i_point_p2,
  input  logic       i_new_game,
  output logic [3:0] o_score_p1d1,
  output logic [3:0] o_score_p1d2,
  output logic [3:0] o_score_p2d1,
  output logic [3:0] o_score_p2d2,
  output logic       o_serve,
  output logic       o_serve_dir,
  output logic       o_play,
  output logic       o_finish,
  output logic [1:0] o_winner
);

  localparam logic [6:0] LIMIT      = 7'(GAME_LIMIT);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [6:0] MAX_SCORE  = 7'd99;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, DONE} state_t;

  state_t     state;
  logic [6:0] score1;
  logic [6:0] score2;
  logic [7:0] serve_cnt;

  // Next-score values, computed in parallel in binary and BCD.
  logic [6:0] score1_inc;
  logic [6:0] score2_inc;
  logic [3:0] p1d1_inc;
  logic [3:0] p1d2_inc;
  logic [3:0] p2d1_inc;
  logic [3:0] p2d2_inc;
  logic       p1_wins;
  logic       p2_wins;
  logic       serve_fire;

  always_comb begin
    score1_inc = score1;
    p1d1_inc   = o_score_p1d1;
    p1d2_inc   = o_score_p1d2;
    if (score1 != MAX_SCORE) begin
      score1_inc = score1 + 7'd1;
      if (o_score_p1d1 == 4'd9) begin
        p1d1_inc = 4'd0;
        p1d2_inc = o_score_p1d2 + 4'd1;
      end else begin
        p1d1_inc = o_score_p1d1 + 4'd1;
      end
    end
  end

  always_comb begin
    score2_inc = score2;
    p2d1_inc   = o_score_p2d1;
    p2d2_inc   = o_score_p2d2;
    if (score2 != MAX_SCORE) begin
      score2_inc = score2 + 7'd1;
      if (o_score_p2d1 == 4'd9) begin
        p2d1_inc = 4'd0;
        p2d2_inc = o_score_p2d2 + 4'd1;
      end else begin
        p2d1_inc = o_score_p2d1 + 4'd1;
      end
    end
  end

  // The win test is evaluated against the post-increment score of the scorer.
`ifdef PONG_WIN_BY_TWO_EN
  logic deuce_at_max;
  always_comb begin
    // Both players pinned at 99: a two-point lead can no longer be built,
    // so the next point decides the game.
    deuce_at_max = (score1 == MAX_SCORE) && (score2 == MAX_SCORE);
    p1_wins = ((score1_inc >= LIMIT) &&
               ({1'b0, score1_inc} >= ({1'b0, score2} + 8'd2))) || deuce_at_max;
    p2_wins = ((score2_inc >= LIMIT) &&
               ({1'b0, score2_inc} >= ({1'b0, score1} + 8'd2))) || deuce_at_max;
  end
`else
  always_comb begin
    p1_wins = (score1_inc == LIMIT);
    p2_wins = (score2_inc == LIMIT);
  end
`endif

  // Serve fires on the tick that completes the delay. Reset and new-game
  // restart the delay, so they suppress the launch in that cycle.
  assign serve_fire = (state == SERVE) && i_frame_tick && (serve_cnt == SERVE_LAST);
  assign o_serve    = serve_fire && !i_rst && !i_new_game;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      score1       <= '0;
      score2       <= '0;
      o_score_p1d1 <= '0;
      o_score_p1d2 <= '0;
      o_score_p2d1 <= '0;
      o_score_p2d2 <= '0;
      serve_cnt    <= '0;
      o_serve_dir  <= 1'b1;
      o_play       <= 1'b0;
      o_finish     <= 1'b0;
      o_winner     <= 2'b00;
    end else if (i_new_game) begin
      state        <= SERVE;
      score1       <= '0;
      score2       <= '0;
      o_score_p1d1 <= '0;
      o_score_p1d2 <= '0;
      o_score_p2d1 <= '0;
      o_score_p2d2 <= '0;
      serve_cnt    <= '0;
      o_serve_dir  <= 1'b1;
      o_play       <= 1'b0;
      o_finish     <= 1'b0;
      o_winner     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          // Scores were cleared on entry to IDLE; nothing to do until a new game.
        end
        SERVE: begin
          if (i_frame_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              serve_cnt <= '0;
              state     <= PLAY;
              o_play    <= 1'b1;
            end else begin
              serve_cnt <= serve_cnt + 8'd1;
            end
          end
        end
        PLAY: begin
          if (i_point_p1 && i_point_p2) begin
            // Simultaneous points: replay the rally in the same direction.
            state     <= SERVE;
            serve_cnt <= '0;
            o_play    <= 1'b0;
          end else if (i_point_p1) begin
            score1       <= score1_inc;
            o_score_p1d1 <= p1d1_inc;
            o_score_p1d2 <= p1d2_inc;
            o_serve_dir  <= 1'b1;
            o_play       <= 1'b0;
            serve_cnt    <= '0;
            if (p1_wins) begin
              state    <= DONE;
              o_finish <= 1'b1;
              o_winner <= 2'b01;
            end else begin
              state <= SERVE;
            end
          end else if (i_point_p2) begin
            score2       <= score2_inc;
            o_score_p2d1 <= p2d1_inc;
            o_score_p2d2 <= p2d2_inc;
            o_serve_dir  <= 1'b0;
            o_play       <= 1'b0;
            serve_cnt    <= '0;
            if (p2_wins) begin
              state    <= DONE;
              o_finish <= 1'b1;
              o_winner <= 2'b10;
            end else begin
              state <= SERVE;
            end
          end
        end
        DONE: begin
          // Frozen until a new game.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
module tb_pong_score_keeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tick [2];
  logic       pt1  [2];
  logic       pt2  [2];
  logic       ng   [2];
  logic [3:0] s1a  [2];
  logic [3:0] s1b  [2];
  logic [3:0] s2a  [2];
  logic [3:0] s2b  [2];
  logic       serve[2];
  logic       dir  [2];
  logic       play [2];
  logic       fin  [2];
  logic [1:0] win  [2];

  int total = 0;
  int bad   = 0;

  // Instance 0: default build (limit 5, 60 frames). Instance 1: limit 15 for the BCD carry test.
  pong_score_keeper u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(tick[0]), .i_point_p1(pt1[0]),
    .i_point_p2(pt2[0]), .i_new_game(ng[0]),
    .o_score_p1d1(s1a[0]), .o_score_p1d2(s1b[0]), .o_score_p2d1(s2a[0]), .o_score_p2d2(s2b[0]),
    .o_serve(serve[0]), .o_serve_dir(dir[0]), .o_play(play[0]), .o_finish(fin[0]),
    .o_winner(win[0])
  );

  pong_score_keeper #(.GAME_LIMIT(15), .SERVE_FRAMES(60)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(tick[1]), .i_point_p1(pt1[1]),
    .i_point_p2(pt2[1]), .i_new_game(ng[1]),
    .o_score_p1d1(s1a[1]), .o_score_p1d2(s1b[1]), .o_score_p2d1(s2a[1]), .o_score_p2d2(s2b[1]),
    .o_serve(serve[1]), .o_serve_dir(dir[1]), .o_play(play[1]), .o_finish(fin[1]),
    .o_winner(win[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pts(input int d, input logic a, input logic b);
    pt1[d] = a;
    pt2[d] = b;
    step();
    pt1[d] = 1'b0;
    pt2[d] = 1'b0;
  endtask

  task automatic new_game(input int d);
    ng[d] = 1'b1;
    step();
    ng[d] = 1'b0;
  endtask

  // Scores as packed BCD {tens, ones}; expected values are given in decimal.
  task automatic chk_score(input int d, input string tag, input int a, input int b);
    chk({tag, "_p1"}, {24'd0, s1b[d], s1a[d]}, 32'(((a / 10) << 4) | (a % 10)));
    chk({tag, "_p2"}, {24'd0, s2b[d], s2a[d]}, 32'(((b / 10) << 4) | (b % 10)));
  endtask

  // Ticks every cycle; serve must fire on the 60th tick and not earlier.
  task automatic serve_wait(input int d, input logic exp_dir, input string tag);
    int early = 0;
    for (int i = 1; i <= 60; i++) begin
      tick[d] = 1'b1;
      #1;
      if (i < 60 && serve[d] === 1'b1) early++;
      if (i == 60) begin
        chk({tag, "_serve"}, {31'd0, serve[d]}, 32'd1);
        chk({tag, "_dir"}, {31'd0, dir[d]}, {31'd0, exp_dir});
      end
      step();
    end
    tick[d] = 1'b0;
    chk({tag, "_early"}, early, 0);
    chk({tag, "_play"}, {31'd0, play[d]}, 32'd1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tick[d] = 1'b0; pt1[d] = 1'b0; pt2[d] = 1'b0; ng[d] = 1'b0;
    end
    step();
    step();

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      chk_score(d, "rst", 0, 0);
      chk("rst_play", {31'd0, play[d]}, 32'd0);
      chk("rst_fin", {31'd0, fin[d]}, 32'd0);
      chk("rst_win", {30'd0, win[d]}, 32'd0);
      chk("rst_dir", {31'd0, dir[d]}, 32'd1);
      chk("rst_serve", {31'd0, serve[d]}, 32'd0);
    end
    rst = 1'b0;

    // Ticks and points in IDLE do nothing.
    cnt = 0;
    tick[0] = 1'b1;
    pt1[0] = 1'b1;
    for (int i = 0; i < 70; i++) begin
      #1;
      if (serve[0] === 1'b1) cnt++;
      step();
    end
    tick[0] = 1'b0;
    pt1[0] = 1'b0;
    chk("idle_noserve", cnt, 0);
    chk_score(0, "idle", 0, 0);

    // New game, first serve after 60 ticks toward player 2.
    new_game(0);
    serve_wait(0, 1'b1, "first");

    // P1 scores: 1-0, serve toward p2. P2 scores: 1-1, serve toward p1.
    pulse_pts(0, 1'b1, 1'b0);
    chk_score(0, "pt_a", 1, 0);
    chk("pt_a_play", {31'd0, play[0]}, 32'd0);
    serve_wait(0, 1'b1, "sv_a");
    pulse_pts(0, 1'b0, 1'b1);
    chk_score(0, "pt_b", 1, 1);
    serve_wait(0, 1'b0, "sv_b");

    // Both at once: no change, replay with the same direction.
    pulse_pts(0, 1'b1, 1'b1);
    chk_score(0, "both", 1, 1);
    chk("both_play", {31'd0, play[0]}, 32'd0);
    chk("both_dir", {31'd0, dir[0]}, 32'd0);

    // Point during SERVE is ignored.
    pulse_pts(0, 1'b1, 1'b0);
    chk_score(0, "srv_pt", 1, 1);
    serve_wait(0, 1'b0, "sv_c");

    // P1 runs to 5 and wins.
    for (int k = 2; k <= 5; k++) begin
      pulse_pts(0, 1'b1, 1'b0);
      if (k < 5) serve_wait(0, 1'b1, "sv_run");
    end
    chk_score(0, "win", 5, 1);
    chk("win_fin", {31'd0, fin[0]}, 32'd1);
    chk("win_who", {30'd0, win[0]}, 32'd1);
    chk("win_play", {31'd0, play[0]}, 32'd0);

    // DONE is frozen.
    pulse_pts(0, 1'b1, 1'b0);
    pulse_pts(0, 1'b0, 1'b1);
    cnt = 0;
    tick[0] = 1'b1;
    for (int i = 0; i < 70; i++) begin
      #1;
      if (serve[0] === 1'b1) cnt++;
      step();
    end
    tick[0] = 1'b0;
    chk_score(0, "done", 5, 1);
    chk("done_noserve", cnt, 0);
    chk("done_fin", {31'd0, fin[0]}, 32'd1);

    // New game from DONE clears everything.
    new_game(0);
    chk_score(0, "ng", 0, 0);
    chk("ng_win", {30'd0, win[0]}, 32'd0);
    chk("ng_fin", {31'd0, fin[0]}, 32'd0);
    chk("ng_dir", {31'd0, dir[0]}, 32'd1);

    // New game mid-SERVE restarts the serve delay.
    tick[0] = 1'b1;
    for (int i = 0; i < 30; i++) step();
    tick[0] = 1'b0;
    new_game(0);
    serve_wait(0, 1'b1, "ng_srv");

    // New game beats a simultaneous point in PLAY.
    pulse_pts(0, 1'b1, 1'b0);
    serve_wait(0, 1'b1, "sv_d");
    pt2[0] = 1'b1;
    ng[0] = 1'b1;
    step();
    pt2[0] = 1'b0;
    ng[0] = 1'b0;
    chk_score(0, "ng_pri", 0, 0);
    chk("ng_pri_dir", {31'd0, dir[0]}, 32'd1);
    chk("ng_pri_play", {31'd0, play[0]}, 32'd0);
    serve_wait(0, 1'b1, "sv_e");

`ifdef PONG_WIN_BY_TWO_EN
    // Win by two: 5-5, then 6-5 continues, 7-5 wins.
    for (int k = 0; k < 5; k++) begin
      pulse_pts(0, 1'b1, 1'b0);
      serve_wait(0, 1'b1, "w2_a");
      pulse_pts(0, 1'b0, 1'b1);
      serve_wait(0, 1'b0, "w2_b");
    end
    chk_score(0, "w2_55", 5, 5);
    pulse_pts(0, 1'b1, 1'b0);
    chk_score(0, "w2_65", 6, 5);
    chk("w2_65_fin", {31'd0, fin[0]}, 32'd0);
    serve_wait(0, 1'b1, "w2_c");
    pulse_pts(0, 1'b1, 1'b0);
    chk_score(0, "w2_75", 7, 5);
    chk("w2_75_win", {30'd0, win[0]}, 32'd1);
    new_game(0);
    serve_wait(0, 1'b1, "w2_d");
`endif

    // BCD carry on the limit-15 instance.
    new_game(1);
    serve_wait(1, 1'b1, "bcd_first");
    for (int k = 1; k <= 12; k++) begin
      pulse_pts(1, 1'b1, 1'b0);
      chk_score(1, "bcd_run", k, 0);
      if (k < 12) serve_wait(1, 1'b1, "bcd_sv");
    end
    chk("bcd_d2", {28'd0, s1b[1]}, 32'd1);
    chk("bcd_d1", {28'd0, s1a[1]}, 32'd2);
    chk("bcd_fin", {31'd0, fin[1]}, 32'd0);

    // Reset mid-PLAY at 3-2 together with a p2 point.
    new_game(0);
    serve_wait(0, 1'b1, "r_sv0");
    pulse_pts(0, 1'b1, 1'b0); serve_wait(0, 1'b1, "r_sv1");
    pulse_pts(0, 1'b0, 1'b1); serve_wait(0, 1'b0, "r_sv2");
    pulse_pts(0, 1'b1, 1'b0); serve_wait(0, 1'b1, "r_sv3");
    pulse_pts(0, 1'b0, 1'b1); serve_wait(0, 1'b0, "r_sv4");
    pulse_pts(0, 1'b1, 1'b0); serve_wait(0, 1'b1, "r_sv5");
    chk_score(0, "pre_rst", 3, 2);
    rst = 1'b1;
    pt2[0] = 1'b1;
    step();
    rst = 1'b0;
    pt2[0] = 1'b0;
    chk_score(0, "mid_rst", 0, 0);
    chk("mid_rst_play", {31'd0, play[0]}, 32'd0);
    chk("mid_rst_dir", {31'd0, dir[0]}, 32'd1);
    cnt = 0;
    tick[0] = 1'b1;
    for (int i = 0; i < 150; i++) begin
      #1;
      if (serve[0] === 1'b1) cnt++;
      step();
    end
    tick[0] = 1'b0;
    chk("post_rst_noserve", cnt, 0);
    chk("post_rst_play", {31'd0, play[0]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
